stall_controller: RTL and testbench
===================================

// Module: stall_controller
// PURPOSE
//  Drives the E (freeze) input of the 2-bit sequence counter and consumes its T output.
//  Freezes the timing sequence for memory waits and halts, then releases it so the counter restarts at T0.
//  Decodes T into one-hot timing strobes for the control unit.
//  Mirrors the counter internally and flags any loss of T synchronisation.
// PARAMETERS
//  MEM_T    2'd1  T state in which mem_req is honoured
//  TIMEOUT  16    max MEM_WAIT cycles before forced release (>=2)
//  CNT_W    8     width of stall_cnt
// PORTS
//  clk          in   1      system clock, all state on posedge
//  rst          in   1      asynchronous, active-high reset
//  T_in         in   2      T from sequence counter
//  mem_req      in   1      control unit requests a memory access
//  mem_ready    in   1      memory access complete
//  halt_req     in   1      request to freeze the sequence indefinitely
//  resume       in   1      leave HALTED
//  E            out  1      freeze to sequence counter (registered)
//  t_dec        out  4      one-hot decode of T_in (combinational), t_dec[T_in]=1
//  mem_start    out  1      1-cycle pulse, first cycle of MEM_WAIT
//  stalled      out  1      1 in MEM_WAIT/HALTED (equals E)
//  timeout_err  out  1      sticky, MEM_WAIT expired without mem_ready
//  sync_err     out  1      sticky, T_in != mirrored T
//  stall_cnt    out  CNT_W  saturating count of cycles with E=1
// BEHAVIOUR
//  Reset: state=IDLE; E, mem_start, stalled, timeout_err, sync_err, stall_cnt, wait_cnt, halt_pend, t_exp all 0.
//   Reset takes effect immediately, including mid-stall (E drops at once).
//  States: IDLE, MEM_WAIT, HALTED, RELEASE; decisions use inputs sampled at posedge.
//  IDLE (E=0):
//   halt_req                -> HALTED, E<=1
//   else mem_req & T_in==MEM_T -> MEM_WAIT, E<=1, mem_start<=1, wait_cnt<=0
//   mem_req in other T states: ignored, no effect
//   halt wins over a simultaneous mem_req; mem_start stays 0
//  MEM_WAIT (E=1), wait_cnt++ each cycle:
//   halt_req                -> halt_pend<=1 (state unchanged)
//   mem_ready               -> HALTED if halt_pend|halt_req, else RELEASE (E<=0)
//   wait_cnt==TIMEOUT-1 without ready -> timeout_err<=1, same exit rule as mem_ready
//   mem_ready on the timeout cycle: ready wins, timeout_err unchanged
//  HALTED (E=1):
//   halt_pend<=0 on entry
//   resume                  -> RELEASE, E<=0
//   halt_req with resume: resume wins
//  RELEASE (E=0): exactly 1 cycle -> IDLE
//   all requests ignored
//   halt_req still high next cycle re-enters HALTED from IDLE
//  Counter contract: E registered here, sampled by counter one edge later.
//   Counter advances once after E rises, holds while E=1,
//   and returns to T0 on the edge after E falls (E 1->0 restart).
//  Mirror t_exp, updated per edge from the current and previous E:
//   prev E=1 & E=0          -> 0
//   E=1                     -> hold
//   otherwise               -> +1 mod 4 (3 wraps to 0)
//   sync_err<=1 when T_in!=t_exp (sticky until rst)
//  stall_cnt: +1 per cycle with E=1, saturates at 2^CNT_W-1.
//  mem_start: 1 only in the first MEM_WAIT cycle.
// STRUCTURE
//  Shared package timing_pkg:
//   state encoding localparams (S_IDLE=0, S_MEM_WAIT=1, S_HALTED=2, S_RELEASE=3)
//   T code constants T0..T3, default MEM_T
//  One sub-module: seq_mirror
//   inputs clk, rst, E, T_in; outputs t_exp, sync_err
//   behavioural counter model + compare
//  FSM, wait/stall counters and decode stay in stall_controller.
// TESTING
//  1. Free run: no requests for 8 cycles -> E=0, t_dec 0001,0010,0100,1000 repeating, sync_err=0.
//  2. Memory wait: mem_req at T_in=1, mem_ready 3 cycles later
//     -> mem_start 1 cycle; E=1 for 3 cycles; 1 RELEASE cycle; T_in=0 after release; stall_cnt=3.
//  3. Timeout: TIMEOUT=4, mem_req at T=1, no ready -> E=1 exactly 4 cycles, timeout_err=1 sticky, then RELEASE.
//     Variant: ready on 4th cycle -> no error.
//  4. Halt priority: halt_req+mem_req together in IDLE -> HALTED, mem_start=0.
//     halt_req during MEM_WAIT -> mem_ready goes straight to HALTED, E stays 1; resume -> RELEASE -> T0.
//  5. Desync: force T_in=2 while mirror expects 0 -> sync_err=1 next edge and remains 1.
//     Saturation: CNT_W=2, 5-cycle halt -> stall_cnt=3.
//  6. Async rst asserted mid-MEM_WAIT between edges
//     -> E=0, all outputs 0 immediately; after release, IDLE and resync from T0.

Source files
------------

// File: rtl/timing_pkg.sv
// rtl/timing_pkg.sv - shared FSM state and T code definitions for the stall controller
package timing_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALTED   = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [1:0] MEM_T_DEFAULT = T1;

endpackage

// File: rtl/seq_mirror.sv
// rtl/seq_mirror.sv - behavioural copy of the 2-bit sequence counter, flags T desync
module seq_mirror
  import timing_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic [1:0] T_in,
  output logic [1:0] t_exp,
  output logic       sync_err
);

  logic e_prev;

  // The counter samples registered E one edge late, so restart follows a 1->0 seen across two edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_prev   <= 1'b0;
      t_exp    <= T0;
      sync_err <= 1'b0;
    end else begin
      e_prev <= E;
      if (e_prev && !E) begin
        t_exp <= T0;
      end else if (!E) begin
        t_exp <= t_exp + 2'd1;
      end
      if (T_in != t_exp) begin
        sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stall_controller.sv
// rtl/stall_controller.sv - freezes the sequence counter for memory waits and halts
module stall_controller
  import timing_pkg::*;
#(
  parameter logic [1:0] MEM_T   = MEM_T_DEFAULT,
  parameter int          TIMEOUT = 16,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       T_in,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             E,
  output logic [3:0]       t_dec,
  output logic             mem_start,
  output logic             stalled,
  output logic             timeout_err,
  output logic             sync_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic              halt_pend, halt_pend_n;
  logic              timeout_n, start_n;
  logic [1:0]        mirror_t_unused;

  always_comb begin
    state_n     = state;
    halt_pend_n = halt_pend;
    timeout_n   = timeout_err;
    start_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (halt_req) begin
          state_n = S_HALTED;
        end else if (mem_req && (T_in == MEM_T)) begin
          state_n = S_MEM_WAIT;
          start_n = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (halt_req) begin
          halt_pend_n = 1'b1;
        end
        // A ready arriving on the final cycle still counts as success.
        if (mem_ready || (wait_cnt == WAIT_LAST)) begin
          if (!mem_ready) begin
            timeout_n = 1'b1;
          end
          if (halt_pend || halt_req) begin
            state_n     = S_HALTED;
            halt_pend_n = 1'b0;
          end else begin
            state_n = S_RELEASE;
          end
        end
      end
      S_HALTED: begin
        if (resume) begin
          state_n = S_RELEASE;
        end
      end
      S_RELEASE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      E           <= 1'b0;
      mem_start   <= 1'b0;
      timeout_err <= 1'b0;
      halt_pend   <= 1'b0;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_n;
      halt_pend   <= halt_pend_n;
      timeout_err <= timeout_n;
      mem_start   <= start_n;
      E           <= (state_n == S_MEM_WAIT) || (state_n == S_HALTED);
      wait_cnt    <= ((state == S_MEM_WAIT) && (state_n == S_MEM_WAIT)) ?
                     wait_cnt + WAIT_W'(1) : '0;
      if (E && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stalled = E;
  assign t_dec   = 4'b0001 << T_in;

  seq_mirror u_mirror (
    .clk      (clk),
    .rst      (rst),
    .E        (E),
    .T_in     (T_in),
    .t_exp    (mirror_t_unused),
    .sync_err (sync_err)
  );

endmodule

// File: tb/tb_stall_controller.sv
// tb/tb_stall_controller.sv - scoreboard bench for stall_controller with counter and FSM reference
module tb_stall_controller;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] T_in;
  logic       mem_req, mem_ready, halt_req, resume;

  logic       E, mem_start, stalled, timeout_err, sync_err;
  logic [3:0] t_dec, stall_cnt;
  logic       E_s, mem_start_s, stalled_s, timeout_err_s, sync_err_s;
  logic [3:0] t_dec_s;
  logic [1:0] stall_cnt_s;

  stall_controller #(.MEM_T(2'd1), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .T_in(T_in), .mem_req(mem_req), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume(resume), .E(E), .t_dec(t_dec), .mem_start(mem_start),
    .stalled(stalled), .timeout_err(timeout_err), .sync_err(sync_err), .stall_cnt(stall_cnt)
  );

  stall_controller #(.MEM_T(2'd1), .TIMEOUT(TO), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .T_in(T_in), .mem_req(mem_req), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume(resume), .E(E_s), .t_dec(t_dec_s), .mem_start(mem_start_s),
    .stalled(stalled_s), .timeout_err(timeout_err_s), .sync_err(sync_err_s), .stall_cnt(stall_cnt_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       e, start, terr, serr;
    logic [3:0] cnt;
    logic [1:0] cnt2;
    logic [3:0] dec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: sequence position as flags, stall time as an unbounded integer.
  bit         m_mem, m_halt, m_rel, m_pend, m_start, m_terr, m_serr, m_e_prev;
  int         m_waited, m_stalls;
  logic [1:0] m_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mem = 0; m_halt = 0; m_rel = 0; m_pend = 0; m_start = 0;
    m_terr = 0; m_serr = 0; m_e_prev = 0; m_waited = 0; m_stalls = 0;
    m_t = 2'd0;
  endtask

  task automatic advance(input bit h, input bit mq, input bit mr, input bit rs, input logic [1:0] tin);
    bit e_now;
    e_now = m_mem || m_halt;
    if (tin != m_t) m_serr = 1;
    if (e_now) m_stalls++;
    if (m_e_prev && !e_now) m_t = 2'd0;
    else if (!e_now)        m_t = m_t + 2'd1;
    m_e_prev = e_now;
    m_start  = 0;
    if (m_rel) begin
      m_rel = 0;
    end else if (m_halt) begin
      if (rs) begin m_halt = 0; m_rel = 1; end
    end else if (m_mem) begin
      m_waited++;
      if (h) m_pend = 1;
      if (mr || m_waited == TO) begin
        if (!mr) m_terr = 1;
        m_mem = 0;
        if (m_pend) begin m_halt = 1; m_pend = 0; end
        else m_rel = 1;
      end
    end else begin
      if (h) m_halt = 1;
      else if (mq && tin == 2'd1) begin m_mem = 1; m_waited = 0; m_start = 1; end
    end
  endtask

  task automatic step(input bit h, input bit mq, input bit mr, input bit rs,
                      input bit frc, input logic [1:0] ft);
    exp_t x;
    @(negedge clk);
    T_in   = frc ? ft : m_t;
    x.e     = m_mem || m_halt;
    x.start = m_start;
    x.terr  = m_terr;
    x.serr  = m_serr;
    x.cnt   = 4'((m_stalls > 15) ? 15 : m_stalls);
    x.cnt2  = 2'((m_stalls > 3) ? 3 : m_stalls);
    x.dec   = 4'b0001 << T_in;
    sb.push_back(x);
    halt_req = h; mem_req = mq; mem_ready = mr; resume = rs;
    advance(h, mq, mr, rs, T_in);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 2'd0);
  endtask

  task automatic align_t1();
    for (int i = 0; i < 8 && m_t != 2'd1; i++) idle();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_E"}, int'(E), 0);
    chk({tag, "_mem_start"}, int'(mem_start), 0);
    chk({tag, "_stalled"}, int'(stalled), 0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
    chk({tag, "_sync_err"}, int'(sync_err), 0);
    chk({tag, "_stall_cnt"}, int'(stall_cnt), 0);
    chk({tag, "_E_sat"}, int'(E_s), 0);
    chk({tag, "_stall_cnt_sat"}, int'(stall_cnt_s), 0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    halt_req = 0; mem_req = 0; mem_ready = 0; resume = 0;
    #1;
    check_cleared(tag);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    T_in = 2'd0;
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("E", int'(E), int'(x.e));
      chk("stalled", int'(stalled), int'(x.e));
      chk("mem_start", int'(mem_start), int'(x.start));
      chk("timeout_err", int'(timeout_err), int'(x.terr));
      chk("sync_err", int'(sync_err), int'(x.serr));
      chk("stall_cnt", int'(stall_cnt), int'(x.cnt));
      chk("t_dec", int'(t_dec), int'(x.dec));
      chk("E_sat", int'(E_s), int'(x.e));
      chk("stalled_sat", int'(stalled_s), int'(x.e));
      chk("mem_start_sat", int'(mem_start_s), int'(x.start));
      chk("timeout_err_sat", int'(timeout_err_s), int'(x.terr));
      chk("sync_err_sat", int'(sync_err_s), int'(x.serr));
      chk("t_dec_sat", int'(t_dec_s), int'(x.dec));
      chk("stall_cnt_sat", int'(stall_cnt_s), int'(x.cnt2));
    end
  end

  initial begin
    rst = 1'b1; T_in = 2'd0;
    halt_req = 0; mem_req = 0; mem_ready = 0; resume = 0;
    model_reset();
    #2;
    check_cleared("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // free run
    repeat (8) idle();
    // memory wait with ready on the third cycle
    align_t1();
    step(0, 1, 0, 0, 0, 2'd0);
    idle(); idle();
    step(0, 0, 1, 0, 0, 2'd0);
    repeat (4) idle();
    // mem_req outside MEM_T is ignored
    for (int i = 0; i < 8 && m_t != 2'd2; i++) idle();
    step(0, 1, 0, 0, 0, 2'd0);
    repeat (2) idle();
    // timeout without ready, then ready on the last cycle
    align_t1();
    step(0, 1, 0, 0, 0, 2'd0);
    repeat (6) idle();
    async_reset("rst_after_timeout");
    align_t1();
    step(0, 1, 0, 0, 0, 2'd0);
    idle(); idle(); idle();
    step(0, 0, 1, 0, 0, 2'd0);
    repeat (3) idle();
    // halt and mem_req together, then halt held through release
    align_t1();
    step(1, 1, 0, 0, 0, 2'd0);
    repeat (5) idle();
    step(1, 0, 0, 1, 0, 2'd0);
    step(1, 0, 0, 0, 0, 2'd0);
    step(1, 0, 0, 0, 0, 2'd0);
    step(0, 0, 0, 1, 0, 2'd0);
    repeat (3) idle();
    // halt during MEM_WAIT turns ready into HALTED
    align_t1();
    step(0, 1, 0, 0, 0, 2'd0);
    step(1, 0, 0, 0, 0, 2'd0);
    step(0, 0, 1, 0, 0, 2'd0);
    repeat (3) idle();
    step(0, 0, 0, 1, 0, 2'd0);
    repeat (3) idle();
    // desync: drive T2 where the counter sits at T0
    for (int i = 0; i < 8 && m_t != 2'd0; i++) idle();
    step(0, 0, 0, 0, 1, 2'd2);
    repeat (4) idle();
    async_reset("rst_after_desync");
    // async reset in the middle of MEM_WAIT
    repeat (3) idle();
    align_t1();
    step(0, 1, 0, 0, 0, 2'd0);
    idle();
    async_reset("rst_mid_wait");
    repeat (6) idle();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset("rst_random");
      end else begin
        step($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0, 2'd0);
      end
    end

    @(negedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
